// File: rtl/tilemap_fetcher.sv
// Tilemap fetcher: per tile slot, fetches the VRAM entry and ROM line for layers A and B and
// presents them to the shift register. Optional late-fetch counter under TILEFETCH_LATECNT_EN.
module tilemap_fetcher #(
  parameter int unsigned VRAM_AW = 12,
  parameter int unsigned CODE_W  = 13
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_MRST_n,
  input  logic                i_EMU_CLK6MPCEN_n,
  input  logic                i_ABS_1H,
  input  logic                i_ABS_2H,
  input  logic                i_ABS_n4H,
  input  logic [VRAM_AW-1:0]  i_A_TILEADDR,
  input  logic [VRAM_AW-1:0]  i_B_TILEADDR,
  input  logic [2:0]          i_ROW,
  output logic [VRAM_AW-1:0]  o_VRAM_ADDR,
  output logic                o_VRAM_RD,
  input  logic [15:0]         i_VRAM_DATA,
  input  logic                i_VRAM_ACK,
  output logic [CODE_W+2:0]   o_ROM_ADDR,
  output logic                o_ROM_RD,
  input  logic [31:0]         i_ROM_DATA,
  input  logic                i_ROM_ACK,
  output logic [31:0]         o_GFXDATA,
  output logic                o_AFF,
  output logic                o_BFF,
`ifdef TILEFETCH_LATECNT_EN
  output logic [15:0]         o_LATE_CNT,
`endif
  output logic                o_LATE
);

  typedef enum logic [1:0] {StIdle, StVrd, StRrd, StDrain} state_e;

  state_e               state_q, state_d;
  logic                 lyr_q, lyr_d;
  logic [VRAM_AW-1:0]   vaddr_q, vaddr_d;
  logic [2:0]           row_q, row_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 hf_q, hf_d;
  logic                 drain_rom_q, drain_rom_d;
  logic                 pend_q, pend_d;
  logic                 pend_lyr_q, pend_lyr_d;
  logic [VRAM_AW-1:0]   pend_addr_q, pend_addr_d;
  logic [2:0]           pend_row_q, pend_row_d;
  logic [31:0]          a_buf_q, a_buf_d, b_buf_q, b_buf_d;
  logic                 a_stage_q, a_stage_d, b_stage_q, b_stage_d;
  logic                 a_done_q, a_done_d, b_done_q, b_done_d;
  logic                 aff_q, aff_d, bff_q, bff_d;
  logic [31:0]          gfx_q, gfx_d;
  logic                 late_q, late_d;

  logic tick, px0, px3, px4, px7, start, start_lyr;
  logic [VRAM_AW-1:0] start_addr;
  logic free, rom_done, a_late, b_late;
  logic unused_vram_bit;

  assign unused_vram_bit = i_VRAM_DATA[15];

  assign tick       = ~i_EMU_CLK6MPCEN_n;
  assign px0        = tick & ~i_ABS_1H & ~i_ABS_2H &  i_ABS_n4H;
  assign px4        = tick & ~i_ABS_1H & ~i_ABS_2H & ~i_ABS_n4H;
  assign px3        = tick &  i_ABS_1H &  i_ABS_2H &  i_ABS_n4H;
  assign px7        = tick &  i_ABS_1H &  i_ABS_2H & ~i_ABS_n4H;
  assign start      = px0 | px4;
  assign start_lyr  = px4;
  assign start_addr = start_lyr ? i_B_TILEADDR : i_A_TILEADDR;

  // Fetch sequencer; "free" means no read is left in flight after this cycle.
  always_comb begin
    state_d     = state_q;
    lyr_d       = lyr_q;
    vaddr_d     = vaddr_q;
    row_d       = row_q;
    code_d      = code_q;
    hf_d        = hf_q;
    drain_rom_d = drain_rom_q;
    pend_d      = pend_q;
    pend_lyr_d  = pend_lyr_q;
    pend_addr_d = pend_addr_q;
    pend_row_d  = pend_row_q;
    free        = 1'b0;
    rom_done    = 1'b0;
    case (state_q)
      StIdle: free = 1'b1;
      StVrd: begin
        if (i_VRAM_ACK) begin
          code_d  = i_VRAM_DATA[CODE_W-1:0];
          hf_d    = i_VRAM_DATA[13];
          row_d   = row_q ^ {3{i_VRAM_DATA[14]}};
          state_d = StRrd;
          free    = 1'b1;
        end
      end
      StRrd: begin
        if (i_ROM_ACK) begin
          rom_done = 1'b1;
          state_d  = StIdle;
          free     = 1'b1;
        end
      end
      StDrain: begin
        if (drain_rom_q ? i_ROM_ACK : i_VRAM_ACK) begin
          state_d = StIdle;
          free    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      if (free) begin
        state_d = StVrd;
        lyr_d   = start_lyr;
        vaddr_d = start_addr;
        row_d   = i_ROW;
        pend_d  = 1'b0;
      end else begin
        pend_d      = 1'b1;
        pend_lyr_d  = start_lyr;
        pend_addr_d = start_addr;
        pend_row_d  = i_ROW;
        if (state_q != StDrain) begin
          state_d     = StDrain;
          drain_rom_d = (state_q == StRrd);
        end
      end
    end else if (free && pend_q) begin
      state_d = StVrd;
      lyr_d   = pend_lyr_q;
      vaddr_d = pend_addr_q;
      row_d   = pend_row_q;
      pend_d  = 1'b0;
    end
  end

  // Line buffers, deadlines and flip staging.
  always_comb begin
    a_late    = px7 & ~a_done_q;
    b_late    = px3 & ~b_done_q;
    a_buf_d   = a_buf_q;
    b_buf_d   = b_buf_q;
    a_stage_d = a_stage_q;
    b_stage_d = b_stage_q;
    a_done_d  = a_done_q;
    b_done_d  = b_done_q;
    if (rom_done && !lyr_q && !a_late) begin
      a_buf_d   = i_ROM_DATA;
      a_stage_d = hf_q;
      a_done_d  = 1'b1;
    end
    if (rom_done && lyr_q && !b_late) begin
      b_buf_d   = i_ROM_DATA;
      b_stage_d = hf_q;
      b_done_d  = 1'b1;
    end
    if (px0) a_done_d = 1'b0;
    if (px4) b_done_d = 1'b0;
    if (a_late) begin
      a_buf_d  = '0;
      a_done_d = 1'b1;
    end
    if (b_late) begin
      b_buf_d  = '0;
      b_done_d = 1'b1;
    end
    aff_d  = px0 ? a_stage_q : aff_q;
    bff_d  = px4 ? b_stage_q : bff_q;
    gfx_d  = i_ABS_n4H ? b_buf_q : a_buf_q;
    late_d = a_late | b_late;
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      state_q     <= StIdle;
      lyr_q       <= 1'b0;
      vaddr_q     <= '0;
      row_q       <= '0;
      code_q      <= '0;
      hf_q        <= 1'b0;
      drain_rom_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_lyr_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_row_q  <= '0;
      a_buf_q     <= '0;
      b_buf_q     <= '0;
      a_stage_q   <= 1'b0;
      b_stage_q   <= 1'b0;
      // Nothing is owed after reset, so the first deadlines must not flag late.
      a_done_q    <= 1'b1;
      b_done_q    <= 1'b1;
      aff_q       <= 1'b0;
      bff_q       <= 1'b0;
      gfx_q       <= '0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lyr_q       <= lyr_d;
      vaddr_q     <= vaddr_d;
      row_q       <= row_d;
      code_q      <= code_d;
      hf_q        <= hf_d;
      drain_rom_q <= drain_rom_d;
      pend_q      <= pend_d;
      pend_lyr_q  <= pend_lyr_d;
      pend_addr_q <= pend_addr_d;
      pend_row_q  <= pend_row_d;
      a_buf_q     <= a_buf_d;
      b_buf_q     <= b_buf_d;
      a_stage_q   <= a_stage_d;
      b_stage_q   <= b_stage_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      aff_q       <= aff_d;
      bff_q       <= bff_d;
      gfx_q       <= gfx_d;
      late_q      <= late_d;
    end
  end

`ifdef TILEFETCH_LATECNT_EN
  logic [15:0] late_cnt_q;

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      late_cnt_q <= '0;
    end else if (late_q && late_cnt_q != 16'hFFFF) begin
      late_cnt_q <= late_cnt_q + 16'd1;
    end
  end

  assign o_LATE_CNT = late_cnt_q;
`endif

  // Requests are decoded from state so an async reset drops them at once.
  assign o_VRAM_RD   = (state_q == StVrd) | ((state_q == StDrain) & ~drain_rom_q);
  assign o_ROM_RD    = (state_q == StRrd) | ((state_q == StDrain) &  drain_rom_q);
  assign o_VRAM_ADDR = vaddr_q;
  assign o_ROM_ADDR  = {code_q, row_q};
  assign o_GFXDATA   = gfx_q;
  assign o_AFF       = aff_q;
  assign o_BFF       = bff_q;
  assign o_LATE      = late_q;

endmodule
